// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory arbiter: default block geometry, FSM state encoding
// and grant-pointer values.
package mem_arbiter_pkg;

    localparam int DMEM_BLOCK_ADDR_SIZE = 10;
    localparam int DBLOCK_SIZE_BITS     = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        I_READ  = 2'd1,
        D_READ  = 2'd2,
        D_WRITE = 2'd3
    } arb_state_t;

    // The pointer records who was granted last; the cleared value favours D.
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    function automatic logic is_read(arb_state_t s);
        return (s == I_READ) || (s == D_READ);
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the I-side, D-side and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_ADDR_W = DMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_BITS   = DBLOCK_SIZE_BITS
) ();

    logic                    i_ren;
    logic [BLOCK_ADDR_W-1:0] i_addr;
    logic                    i_ready;
    logic [BLOCK_BITS-1:0]   i_dout;

    logic                    d_ren;
    logic                    d_wen;
    logic [BLOCK_ADDR_W-1:0] d_addr;
    logic [BLOCK_BITS-1:0]   d_din;
    logic                    d_ready;
    logic                    d_done;
    logic [BLOCK_BITS-1:0]   d_dout;

    logic                    mem_ren;
    logic                    mem_wen;
    logic [BLOCK_ADDR_W-1:0] mem_addr;
    logic [BLOCK_BITS-1:0]   mem_din;
    logic                    mem_ready;
    logic                    mem_done;
    logic [BLOCK_BITS-1:0]   mem_dout;

    modport slave (
        input  i_ren, i_addr, d_ren, d_wen, d_addr, d_din,
        input  mem_ready, mem_done, mem_dout,
        output i_ready, i_dout, d_ready, d_done, d_dout,
        output mem_ren, mem_wen, mem_addr, mem_din
    );

    modport master (
        output i_ren, i_addr, d_ren, d_wen, d_addr, d_din,
        output mem_ready, mem_done, mem_dout,
        input  i_ready, i_dout, d_ready, d_done, d_dout,
        input  mem_ren, mem_wen, mem_addr, mem_din
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection used while the arbiter is idle.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin between I and D; otherwise D has fixed priority.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_req,
    input  logic       d_rd,
    input  logic       d_wr,
    input  logic       last_grant,
    output arb_state_t next_state
);

    logic       d_req;
    arb_state_t d_op;

    // A pending D write always goes ahead of a D read issued alongside it.
    assign d_req = d_rd | d_wr;
    assign d_op  = d_wr ? D_WRITE : D_READ;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        next_state = IDLE;
        if (d_req && i_req) begin
            next_state = (last_grant == GRANT_D) ? I_READ : d_op;
        end else if (d_req) begin
            next_state = d_op;
        end else if (i_req) begin
            next_state = I_READ;
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        next_state = IDLE;
        if (d_req) begin
            next_state = d_op;
        end else if (i_req) begin
            next_state = I_READ;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one instruction-side and one data-side requester onto a single block memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin I/D arbitration instead of fixed D priority.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_ADDR_W = DMEM_BLOCK_ADDR_SIZE,
    parameter int BLOCK_BITS   = DBLOCK_SIZE_BITS
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    arb_state_t              state;
    arb_state_t              next_state;
    arb_state_t              pick_state;
    logic                    last_grant;
    logic                    mem_ren_q;
    logic                    mem_wen_q;
    logic [BLOCK_ADDR_W-1:0] addr_q;
    logic [BLOCK_BITS-1:0]   din_q;

    mem_arb_pick u_pick (
        .i_req      (bus.i_ren),
        .d_rd       (bus.d_ren),
        .d_wr       (bus.d_wen),
        .last_grant (last_grant),
        .next_state (pick_state)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Requests only matter in IDLE; a busy state waits solely for its own completion strobe.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:           next_state = pick_state;
            I_READ, D_READ: if (bus.mem_ready) next_state = IDLE;
            D_WRITE:        if (bus.mem_done)  next_state = IDLE;
            default:        next_state = IDLE;
        endcase
    end

    // Memory strobes follow the next state so they rise on the same edge as the grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            addr_q    <= '0;
            din_q     <= '0;
        end else begin
            mem_ren_q <= is_read(next_state);
            mem_wen_q <= (next_state == D_WRITE);
            if (state == IDLE) begin
                case (pick_state)
                    I_READ:  addr_q <= bus.i_addr;
                    D_READ:  addr_q <= bus.d_addr;
                    D_WRITE: begin
                        addr_q <= bus.d_addr;
                        din_q  <= bus.d_din;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= GRANT_I;
        end else if ((state == IDLE) && (pick_state != IDLE)) begin
            last_grant <= (pick_state == I_READ) ? GRANT_I : GRANT_D;
        end
    end
`else
    assign last_grant = GRANT_I;
`endif

    assign bus.mem_ren  = mem_ren_q;
    assign bus.mem_wen  = mem_wen_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;

    // Gating with rst keeps an abandoned transaction from leaking a completion pulse.
    assign bus.i_ready  = !rst && (state == I_READ)  && bus.mem_ready;
    assign bus.d_ready  = !rst && (state == D_READ)  && bus.mem_ready;
    assign bus.d_done   = !rst && (state == D_WRITE) && bus.mem_done;
    assign bus.i_dout   = bus.mem_dout;
    assign bus.d_dout   = bus.mem_dout;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; expectations cover both the fixed-priority
// and the MEM_ARB_ROUND_ROBIN_EN builds.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [127:0] pat_a5;
    logic [127:0] pat_3c;
    logic [127:0] pat_5a;
    logic [127:0] rr_first;
    logic [127:0] rr_second;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic i_ren, input logic [9:0] i_addr,
                                 input logic d_ren, input logic d_wen,
                                 input logic [9:0] d_addr, input logic [127:0] d_din);
        bus.i_ren  = i_ren;
        bus.i_addr = i_addr;
        bus.d_ren  = d_ren;
        bus.d_wen  = d_wen;
        bus.d_addr = d_addr;
        bus.d_din  = d_din;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        pat_a5 = {16{8'hA5}};
        pat_3c = {16{8'h3C}};
        pat_5a = {16{8'h5A}};
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 128'h0);
        bus.mem_ready = 1'b0;
        bus.mem_done  = 1'b0;
        bus.mem_dout  = '0;

        // Reset state
        stepClock();
        stepClock();
        checkOutput("rst_mem_ren", bus.mem_ren, 1'b0);
        checkOutput("rst_mem_wen", bus.mem_wen, 1'b0);
        checkOutput("rst_mem_addr", bus.mem_addr, 10'h000);
        checkOutput("rst_mem_din", bus.mem_din, 128'h0);
        checkOutput("rst_i_ready", bus.i_ready, 1'b0);
        checkOutput("rst_d_ready", bus.d_ready, 1'b0);
        checkOutput("rst_d_done", bus.d_done, 1'b0);
        rst = 1'b0;

        // Scenario 1: single instruction read
        $display("[TB] scenario 1: I read");
        applyStimulus(1'b1, 10'h012, 1'b0, 1'b0, 10'h000, 128'h0);
        stepClock();
        checkOutput("s1_mem_ren", bus.mem_ren, 1'b1);
        checkOutput("s1_mem_wen", bus.mem_wen, 1'b0);
        checkOutput("s1_mem_addr", bus.mem_addr, 10'h012);
        checkOutput("s1_i_ready_wait", bus.i_ready, 1'b0);
        bus.mem_ready = 1'b1;
        bus.mem_dout  = pat_a5;
        #1;
        checkOutput("s1_i_ready", bus.i_ready, 1'b1);
        checkOutput("s1_i_dout", bus.i_dout, pat_a5);
        checkOutput("s1_d_ready", bus.d_ready, 1'b0);
        stepClock();
        bus.i_ren     = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checkOutput("s1_idle_mem_ren", bus.mem_ren, 1'b0);
        checkOutput("s1_idle_i_ready", bus.i_ready, 1'b0);

        // Scenario 2: D write held five cycles, with a stray mem_ready ignored
        $display("[TB] scenario 2: D write");
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b1, 10'h3FF, 128'h1234);
        stepClock();
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) stepClock();
            bus.mem_ready = (k == 3);
            #1;
            checkOutput($sformatf("s2_mem_wen_c%0d", k), bus.mem_wen, 1'b1);
            checkOutput($sformatf("s2_mem_ren_c%0d", k), bus.mem_ren, 1'b0);
            checkOutput($sformatf("s2_mem_addr_c%0d", k), bus.mem_addr, 10'h3FF);
            checkOutput($sformatf("s2_mem_din_c%0d", k), bus.mem_din, 128'h1234);
            checkOutput($sformatf("s2_d_ready_c%0d", k), bus.d_ready, 1'b0);
            checkOutput($sformatf("s2_d_done_c%0d", k), bus.d_done, 1'b0);
        end
        bus.mem_done = 1'b1;
        #1;
        checkOutput("s2_d_done", bus.d_done, 1'b1);
        checkOutput("s2_i_ready", bus.i_ready, 1'b0);
        stepClock();
        checkOutput("s2_d_done_one_cycle", bus.d_done, 1'b0);
        bus.d_wen    = 1'b0;
        bus.mem_done = 1'b0;
        #1;
        checkOutput("s2_idle_mem_wen", bus.mem_wen, 1'b0);

        // Scenario 3: I/D collisions from a fresh reset
        $display("[TB] scenario 3: collisions");
        rst = 1'b1;
        stepClock();
        rst = 1'b0;
        applyStimulus(1'b1, 10'h055, 1'b1, 1'b0, 10'h0AA, 128'h0);
        stepClock();
        checkOutput("s3a_first_addr", bus.mem_addr, 10'h0AA);
        checkOutput("s3a_first_ren", bus.mem_ren, 1'b1);
        bus.mem_ready = 1'b1;
        bus.mem_dout  = pat_3c;
        #1;
        checkOutput("s3a_d_ready", bus.d_ready, 1'b1);
        checkOutput("s3a_d_dout", bus.d_dout, pat_3c);
        checkOutput("s3a_i_ready_blocked", bus.i_ready, 1'b0);
        stepClock();
        bus.d_ren     = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checkOutput("s3a_dead_cycle_ren", bus.mem_ren, 1'b0);
        stepClock();
        checkOutput("s3a_second_addr", bus.mem_addr, 10'h055);
        checkOutput("s3a_second_ren", bus.mem_ren, 1'b1);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("s3a_i_ready", bus.i_ready, 1'b1);
        checkOutput("s3a_d_ready_low", bus.d_ready, 1'b0);
        stepClock();
        bus.i_ren     = 1'b0;
        bus.mem_ready = 1'b0;

        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h100, 128'h0);
        stepClock();
        checkOutput("s3b_d_only_addr", bus.mem_addr, 10'h100);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("s3b_d_only_ready", bus.d_ready, 1'b1);
        stepClock();
        bus.d_ren     = 1'b0;
        bus.mem_ready = 1'b0;

`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_first  = 128'h077;
        rr_second = 128'h0CC;
`else
        rr_first  = 128'h0CC;
        rr_second = 128'h077;
`endif
        applyStimulus(1'b1, 10'h077, 1'b1, 1'b0, 10'h0CC, 128'h0);
        stepClock();
        checkOutput("s3c_first_addr", bus.mem_addr, rr_first);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("s3c_first_i_ready", bus.i_ready, rr_first == 128'h077);
        checkOutput("s3c_first_d_ready", bus.d_ready, rr_first == 128'h0CC);
        stepClock();
        if (rr_first == 128'h077) bus.i_ren = 1'b0;
        else                      bus.d_ren = 1'b0;
        bus.mem_ready = 1'b0;
        stepClock();
        checkOutput("s3c_second_addr", bus.mem_addr, rr_second);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("s3c_second_i_ready", bus.i_ready, rr_second == 128'h077);
        checkOutput("s3c_second_d_ready", bus.d_ready, rr_second == 128'h0CC);
        stepClock();
        applyStimulus(1'b0, 10'h000, 1'b0, 1'b0, 10'h000, 128'h0);
        bus.mem_ready = 1'b0;

        // Scenario 4: simultaneous D read and write
        $display("[TB] scenario 4: D read+write");
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b1, 10'h200, 128'hDEAD);
        stepClock();
        checkOutput("s4_wr_mem_wen", bus.mem_wen, 1'b1);
        checkOutput("s4_wr_mem_ren", bus.mem_ren, 1'b0);
        checkOutput("s4_wr_mem_din", bus.mem_din, 128'hDEAD);
        bus.mem_done = 1'b1;
        #1;
        checkOutput("s4_d_done", bus.d_done, 1'b1);
        checkOutput("s4_d_ready_low", bus.d_ready, 1'b0);
        stepClock();
        bus.d_wen    = 1'b0;
        bus.mem_done = 1'b0;
        #1;
        checkOutput("s4_dead_both_low", {bus.mem_ren, bus.mem_wen}, 2'b00);
        stepClock();
        checkOutput("s4_rd_strobes", {bus.mem_ren, bus.mem_wen}, 2'b10);
        checkOutput("s4_rd_addr", bus.mem_addr, 10'h200);
        bus.mem_ready = 1'b1;
        bus.mem_dout  = pat_5a;
        #1;
        checkOutput("s4_d_ready", bus.d_ready, 1'b1);
        checkOutput("s4_d_dout", bus.d_dout, pat_5a);
        stepClock();
        bus.d_ren     = 1'b0;
        bus.mem_ready = 1'b0;

        // Scenario 5: reset two cycles into a D read
        $display("[TB] scenario 5: reset mid-read");
        applyStimulus(1'b0, 10'h000, 1'b1, 1'b0, 10'h321, 128'h0);
        stepClock();
        checkOutput("s5_rd_cycle1", bus.mem_ren, 1'b1);
        stepClock();
        checkOutput("s5_rd_cycle2", bus.mem_ren, 1'b1);
        rst = 1'b1;
        stepClock();
        rst       = 1'b0;
        bus.d_ren = 1'b0;
        checkOutput("s5_after_rst_ren", bus.mem_ren, 1'b0);
        checkOutput("s5_after_rst_addr", bus.mem_addr, 10'h000);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("s5_late_d_ready", bus.d_ready, 1'b0);
        stepClock();
        bus.mem_ready = 1'b0;
        checkOutput("s5_stays_idle", bus.mem_ren, 1'b0);

        // Scenario 6: stray mem_done during an I read
        $display("[TB] scenario 6: stray mem_done");
        applyStimulus(1'b1, 10'h0F0, 1'b0, 1'b0, 10'h000, 128'h0);
        stepClock();
        bus.mem_done = 1'b1;
        #1;
        checkOutput("s6_i_ready_low", bus.i_ready, 1'b0);
        checkOutput("s6_d_done_low", bus.d_done, 1'b0);
        stepClock();
        bus.mem_done = 1'b0;
        checkOutput("s6_ren_held", bus.mem_ren, 1'b1);
        checkOutput("s6_addr_held", bus.mem_addr, 10'h0F0);
        bus.mem_ready = 1'b1;
        #1;
        checkOutput("s6_i_ready", bus.i_ready, 1'b1);
        stepClock();
        bus.i_ren     = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        checkOutput("s6_idle_ren", bus.mem_ren, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter BLOCK_ADDR_W, default 10, block address width shared by both requesters and memory.
REQ-002 SHALL have parameter BLOCK_BITS, default 128, data block width in bits.
REQ-003 SHALL have one clock and a synchronous, active-high reset: clock input 1, single clock, all state updates on rising edge; reset input 1.
REQ-004 SHALL have I-side ports: i_ren input 1, instruction block read request; i_addr input BLOCK_ADDR_W, block address; i_ready output 1, read complete; i_dout output BLOCK_BITS, read data.
REQ-005 SHALL have D-side request ports: d_ren input 1, data block read request; d_wen input 1, data block write request; d_addr input BLOCK_ADDR_W, block address; d_din input BLOCK_BITS, write data.
REQ-006 SHALL have D-side response ports: d_ready output 1, read complete; d_done output 1, write complete; d_dout output BLOCK_BITS, read data.
REQ-007 SHALL have memory-side ports: mem_ren output 1; mem_wen output 1; mem_addr output BLOCK_ADDR_W; mem_din output BLOCK_BITS; mem_ready input 1, read complete; mem_done input 1, write complete; mem_dout input BLOCK_BITS.

Function
REQ-008 SHALL implement FSM states IDLE, I_READ, D_READ, D_WRITE.
REQ-009 In IDLE, SHALL sample requests, latch the winner's address (and d_din for writes) into registers, and move to the corresponding state on the next edge.
REQ-010 Memory outputs SHALL be registered and driven from the latched values only: mem_ren high in I_READ/D_READ, mem_wen high in D_WRITE, both low in IDLE.
REQ-011 Minimum latency: request seen in IDLE at cycle N; mem_ren/mem_wen high at cycle N+1.
REQ-012 SHALL hold mem_* outputs stable until mem_ready (reads) or mem_done (write).
REQ-013 SHALL pass i_ready/d_ready/d_done combinationally as mem_ready/mem_done gated by the current state, so exactly the granted requester sees one pulse.
REQ-014 SHALL forward mem_dout to i_dout/d_dout unchanged; data is valid only while the matching ready is high.
REQ-015 On completion, SHALL return to IDLE, giving exactly one dead cycle between back-to-back grants.
REQ-016 Requesters hold requests until their ready/done; requests are sampled only in IDLE.
REQ-017 With d_ren and d_wen both high, SHALL serve the write first; the read remains pending and is served at a later grant.
REQ-018 mem_ready in a write state, or mem_done in a read state, SHALL be ignored.
REQ-019 Non-granted requesters SHALL see ready/done low regardless of memory activity.

Reset
REQ-020 Reset SHALL force IDLE, drive mem_ren=0 and mem_wen=0, clear the latched address/data registers and the priority pointer to zero; i_ready, d_ready and d_done are then 0.
REQ-021 Reset mid-transaction SHALL abandon it with no completion pulse to any requester.

Configuration
REQ-022 Macro MEM_ARB_ROUND_ROBIN_EN: when defined, under simultaneous I and D requests in IDLE, the requester not granted last SHALL win (pointer resets to favour D).
REQ-023 When MEM_ARB_ROUND_ROBIN_EN is undefined, D SHALL always win over I (fixed priority) and no pointer is instantiated.

Structure
REQ-024 The state encoding and default widths SHALL live in the shared constants include, and the widths SHALL be driven by DMEM_BLOCK_ADDR_SIZE and DBLOCK_SIZE_BITS.
REQ-025 SHALL have one sub-module, mem_arb_pick: combinational grant selection from (i_req, d_rd, d_wr, last_grant) producing the next state.

Verification
REQ-026 Scenario 1: reset, then i_ren=1, i_addr=0x012 -> mem_ren=1, mem_addr=0x012 next cycle; mem_ready with mem_dout=0xA5..A5 -> i_ready=1, i_dout=0xA5..A5 same cycle; d_ready=0.
REQ-027 Scenario 2: d_wen=1, d_addr=0x3FF, d_din=0x1234 -> mem_wen=1, mem_din=0x1234 held for 5 cycles until mem_done -> d_done pulse 1 cycle, then IDLE.
REQ-028 Scenario 3: i_ren and d_ren in the same cycle, fixed priority -> D served first, I served after one dead cycle; round-robin build, second collision -> I served first.
REQ-029 Scenario 4: d_ren=1, d_wen=1 together -> write completes (d_done), then read completes (d_ready); never mem_ren and mem_wen high together.
REQ-030 Scenario 5: reset asserted 2 cycles into D_READ -> next cycle mem_ren=0, state IDLE; a late mem_ready produces no d_ready.
REQ-031 Scenario 6: stray mem_done during I_READ -> ignored, mem_ren stays high until mem_ready.
